// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the data-RAM port arbiter.
package mem_arb_pkg;
  localparam int ADDR_W  = 16;
  localparam int VADDR_W = 12;
  localparam int SDATA_W = 8;
  localparam int VDATA_W = 128;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CPU   = 2'd1,
    LDR   = 2'd2,
    FORCE = 2'd3
  } arb_state_e;
endpackage

// File: rtl/arb_starve_counter.sv
// Counts cycles the loader is kept waiting by the CPU; flags when the limit is reached.
module arb_starve_counter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ldr_req,
  input  logic cpu_win,
  input  logic ldr_win,
  output logic at_limit
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_reg, cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (!ldr_req || ldr_win) begin
      cnt_next = '0;
    end else if (cpu_win && cnt_reg != LIMIT) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_reg <= '0;
    else        cnt_reg <= cnt_next;
  end

  assign at_limit = (cnt_reg == LIMIT);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the dual-port data RAM between the CPU memory stage (priority) and a bulk loader.
// ARB_STARVE_GUARD_EN adds a starvation guard that forces a one-cycle loader grant.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_req,
  input  logic               cpu_we_a,
  input  logic               cpu_we_b,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [SDATA_W-1:0] cpu_wdata_a,
  input  logic [VDATA_W-1:0] cpu_wdata_b,
  output logic               cpu_stall,
  output logic               cpu_rvalid,
  output logic [SDATA_W-1:0] cpu_rdata_a,
  output logic [VDATA_W-1:0] cpu_rdata_b,
  input  logic               ldr_req,
  input  logic               ldr_we,
  input  logic               ldr_vec,
  input  logic [ADDR_W-1:0]  ldr_addr,
  input  logic [VDATA_W-1:0] ldr_wdata,
  output logic               ldr_gnt,
  output logic               ldr_rvalid,
  output logic [VDATA_W-1:0] ldr_rdata,
  output logic [ADDR_W-1:0]  ram_address_a,
  output logic [VADDR_W-1:0] ram_address_b,
  output logic [SDATA_W-1:0] ram_data_a,
  output logic [VDATA_W-1:0] ram_data_b,
  output logic               ram_wren_a,
  output logic               ram_wren_b,
  input  logic [SDATA_W-1:0] ram_q_a,
  input  logic [VDATA_W-1:0] ram_q_b
);
  arb_state_e state_reg, state_next;
  logic       rd_reg, rd_next;
  logic       vec_reg, vec_next;
  logic       force_win, cpu_win, ldr_win, any_we;
  logic [SDATA_W-1:0] cpu_hold_a_reg;
  logic [VDATA_W-1:0] cpu_hold_b_reg, ldr_hold_reg, ldr_q;

`ifdef ARB_STARVE_GUARD_EN
  logic at_limit;

  arb_starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .clk      (clk),
    .reset    (reset),
    .ldr_req  (ldr_req),
    .cpu_win  (cpu_win),
    .ldr_win  (ldr_win),
    .at_limit (at_limit)
  );

  assign force_win = reset & ldr_req & at_limit;
`else
  logic unused_limit;
  assign unused_limit = (STARVE_LIMIT == 0);
  assign force_win    = 1'b0;
`endif

  // Grants are gated by reset so every output reads 0 while reset is held.
  assign cpu_win   = reset & cpu_req & ~force_win;
  assign ldr_win   = reset & ldr_req & (force_win | ~cpu_req);
  assign ldr_gnt   = ldr_win;
  assign cpu_stall = force_win & cpu_req;

  always_comb begin
    ram_address_a = '0;
    ram_address_b = '0;
    ram_data_a    = '0;
    ram_data_b    = '0;
    ram_wren_a    = 1'b0;
    ram_wren_b    = 1'b0;
    any_we        = 1'b0;
    state_next    = IDLE;
    vec_next      = 1'b0;
    if (cpu_win) begin
      ram_address_a = cpu_addr;
      ram_address_b = cpu_addr[VADDR_W-1:0];
      ram_data_a    = cpu_wdata_a;
      ram_data_b    = cpu_wdata_b;
      ram_wren_a    = cpu_we_a;
      ram_wren_b    = cpu_we_b;
      any_we        = cpu_we_a | cpu_we_b;
      state_next    = CPU;
    end else if (ldr_win) begin
      if (ldr_vec) begin
        ram_address_b = ldr_addr[VADDR_W-1:0];
        ram_data_b    = ldr_wdata;
        ram_wren_b    = ldr_we;
      end else begin
        ram_address_a = ldr_addr;
        ram_data_a    = ldr_wdata[SDATA_W-1:0];
        ram_wren_a    = ldr_we;
      end
      any_we     = ldr_we;
      vec_next   = ldr_vec;
      state_next = force_win ? FORCE : LDR;
    end
    rd_next = (cpu_win | ldr_win) & ~any_we;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      rd_reg    <= 1'b0;
      vec_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      rd_reg    <= rd_next;
      vec_reg   <= vec_next;
    end
  end

  assign cpu_rvalid = rd_reg & (state_reg == CPU);
  assign ldr_rvalid = rd_reg & ((state_reg == LDR) | (state_reg == FORCE));
  assign ldr_q      = vec_reg ? ram_q_b : {{(VDATA_W-SDATA_W){1'b0}}, ram_q_a};

  // Read data passes straight through on rvalid and is held afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_hold_a_reg <= '0;
      cpu_hold_b_reg <= '0;
      ldr_hold_reg   <= '0;
    end else begin
      if (cpu_rvalid) begin
        cpu_hold_a_reg <= ram_q_a;
        cpu_hold_b_reg <= ram_q_b;
      end
      if (ldr_rvalid) ldr_hold_reg <= ldr_q;
    end
  end

  assign cpu_rdata_a = cpu_rvalid ? ram_q_a : cpu_hold_a_reg;
  assign cpu_rdata_b = cpu_rvalid ? ram_q_b : cpu_hold_b_reg;
  assign ldr_rdata   = ldr_rvalid ? ldr_q   : ldr_hold_reg;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed pins plus randomized traffic vs a reference model.
module tb_mem_port_arbiter;
  localparam int LIMIT = 8;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cpu_req = 0, cpu_we_a = 0, cpu_we_b = 0;
  logic [15:0] cpu_addr = '0;
  logic [7:0] cpu_wdata_a = '0;
  logic [127:0] cpu_wdata_b = '0;
  logic cpu_stall, cpu_rvalid;
  logic [7:0] cpu_rdata_a;
  logic [127:0] cpu_rdata_b;
  logic ldr_req = 0, ldr_we = 0, ldr_vec = 0;
  logic [15:0] ldr_addr = '0;
  logic [127:0] ldr_wdata = '0;
  logic ldr_gnt, ldr_rvalid;
  logic [127:0] ldr_rdata;
  logic [15:0] ram_address_a;
  logic [11:0] ram_address_b;
  logic [7:0] ram_data_a;
  logic [127:0] ram_data_b;
  logic ram_wren_a, ram_wren_b;
  logic [7:0] ram_q_a = '0;
  logic [127:0] ram_q_b = '0;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we_a(cpu_we_a), .cpu_we_b(cpu_we_b), .cpu_addr(cpu_addr),
    .cpu_wdata_a(cpu_wdata_a), .cpu_wdata_b(cpu_wdata_b), .cpu_stall(cpu_stall),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata_a(cpu_rdata_a), .cpu_rdata_b(cpu_rdata_b),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_vec(ldr_vec), .ldr_addr(ldr_addr),
    .ldr_wdata(ldr_wdata), .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
    .ram_address_a(ram_address_a), .ram_address_b(ram_address_b),
    .ram_data_a(ram_data_a), .ram_data_b(ram_data_b),
    .ram_wren_a(ram_wren_a), .ram_wren_b(ram_wren_b),
    .ram_q_a(ram_q_a), .ram_q_b(ram_q_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who is waiting, who owns the outstanding read, what each requester last saw.
  int denied = 0;
  bit pend_valid = 0;
  bit pend_ldr = 0;
  bit pend_vec = 0;
  logic [7:0] hold_ca = '0;
  logic [127:0] hold_cb = '0, hold_l = '0;

  // 0 nobody, 1 CPU, 2 loader (normal), 3 loader (forced)
  function automatic int winner();
    if (!reset) return 0;
    if (GUARD && ldr_req && denied == LIMIT) return 3;
    if (cpu_req) return 1;
    if (ldr_req) return 2;
    return 0;
  endfunction

  function automatic bit wins_write(input int w);
    if (w == 1) return cpu_we_a | cpu_we_b;
    if (w >= 2) return ldr_we;
    return 1'b0;
  endfunction

  function automatic logic [127:0] ldr_view();
    return pend_vec ? ram_q_b : {120'b0, ram_q_a};
  endfunction

  always @(posedge clk) begin : model_update
    int w;
    w = winner();
    if (!reset) begin
      denied <= 0; pend_valid <= 0; pend_ldr <= 0; pend_vec <= 0;
      hold_ca <= '0; hold_cb <= '0; hold_l <= '0;
    end else begin
      if (pend_valid && !pend_ldr) begin
        hold_ca <= ram_q_a;
        hold_cb <= ram_q_b;
      end
      if (pend_valid && pend_ldr) hold_l <= ldr_view();
      pend_valid <= (w != 0) && !wins_write(w);
      pend_ldr   <= (w >= 2);
      pend_vec   <= (w >= 2) && ldr_vec;
      if (!ldr_req || w >= 2) denied <= 0;
      else if (w == 1) denied <= (denied < LIMIT) ? denied + 1 : LIMIT;
    end
  end

  always @(negedge clk) begin : compare
    int w;
    logic [15:0] ea_a;
    logic [11:0] ea_b;
    logic [7:0] ed_a;
    logic [127:0] ed_b;
    logic ew_a, ew_b, ecv, elv;
    w = winner();
    ea_a = '0; ea_b = '0; ed_a = '0; ed_b = '0; ew_a = 0; ew_b = 0;
    if (w == 1) begin
      ea_a = cpu_addr; ea_b = cpu_addr[11:0]; ed_a = cpu_wdata_a; ed_b = cpu_wdata_b;
      ew_a = cpu_we_a; ew_b = cpu_we_b;
    end else if (w >= 2 && ldr_vec) begin
      ea_b = ldr_addr[11:0]; ed_b = ldr_wdata; ew_b = ldr_we;
    end else if (w >= 2) begin
      ea_a = ldr_addr; ed_a = ldr_wdata[7:0]; ew_a = ldr_we;
    end
    ecv = reset && pend_valid && !pend_ldr;
    elv = reset && pend_valid && pend_ldr;
    chk("ldr_gnt", ldr_gnt, w >= 2);
    chk("cpu_stall", cpu_stall, w == 3 && cpu_req);
    chk("ram_address_a", ram_address_a, ea_a);
    chk("ram_address_b", ram_address_b, ea_b);
    chk("ram_data_a", ram_data_a, ed_a);
    chk("ram_data_b", ram_data_b, ed_b);
    chk("ram_wren_a", ram_wren_a, ew_a);
    chk("ram_wren_b", ram_wren_b, ew_b);
    chk("cpu_rvalid", cpu_rvalid, ecv);
    chk("ldr_rvalid", ldr_rvalid, elv);
    chk("cpu_rdata_a", cpu_rdata_a, !reset ? 8'h0 : ecv ? ram_q_a : hold_ca);
    chk("cpu_rdata_b", cpu_rdata_b, !reset ? 128'h0 : ecv ? ram_q_b : hold_cb);
    chk("ldr_rdata", ldr_rdata, !reset ? 128'h0 : elv ? ldr_view() : hold_l);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we_a = 0; cpu_we_b = 0; ldr_req = 0; ldr_we = 0; ldr_vec = 0;
  endtask

  initial begin
    // Reset held with both requesters active: everything quiet.
    cpu_req = 1; cpu_we_a = 1; ldr_req = 1; ldr_we = 1; ldr_vec = 1;
    cpu_addr = 16'h1234; ldr_addr = 16'h0456;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_ldr_gnt", ldr_gnt, 0);
    chk("rst_wren", {ram_wren_a, ram_wren_b}, 0);
    chk("rst_addr_a", ram_address_a, 0);
    chk("rst_rdata", ldr_rdata, 0);

    // First grant after release goes to the CPU; scalar read at 0x0010.
    step();
    reset = 1; cpu_we_a = 0; ldr_we = 0; cpu_addr = 16'h0010;
    #3;
    chk("first_cpu_addr", ram_address_a, 16'h0010);
    chk("first_ldr_gnt", ldr_gnt, 0);
    step();
    idle(); ram_q_a = 8'h5A;
    #3;
    chk("cpu_rd_valid", cpu_rvalid, 1);
    chk("cpu_rd_data", cpu_rdata_a, 8'h5A);

    // Loader vector write alone.
    step();
    ldr_req = 1; ldr_we = 1; ldr_vec = 1; ldr_addr = 16'h0200; ldr_wdata = {16{8'hA5}};
    #3;
    chk("lw_gnt", ldr_gnt, 1);
    chk("lw_wren_b", ram_wren_b, 1);
    chk("lw_addr_b", ram_address_b, 12'h200);
    chk("lw_wren_a", ram_wren_a, 0);
    step();
    idle();
    #3;
    chk("lw_no_rvalid", ldr_rvalid, 0);

    // Continuous contention: both requesters read every cycle.
    step();
    cpu_req = 1; ldr_req = 1; ldr_vec = 1; cpu_addr = 16'h0777; ldr_addr = 16'h0099;
    for (int c = 1; c <= 12; c++) begin
      #3;
      chk($sformatf("starve_gnt_c%0d", c), ldr_gnt, GUARD && c == 9);
      chk($sformatf("starve_stall_c%0d", c), cpu_stall, GUARD && c == 9);
      chk($sformatf("starve_addr_a_c%0d", c), ram_address_a, (GUARD && c == 9) ? 16'h0 : 16'h0777);
      chk($sformatf("starve_lrv_c%0d", c), ldr_rvalid, GUARD && c == 10);
      step();
    end

    // Loader read granted, reset asserted the next cycle: its return is dropped.
    idle();
    step();
    ldr_req = 1; ldr_addr = 16'h0033;
    #3;
    chk("lr_gnt", ldr_gnt, 1);
    step();
    idle(); reset = 0;
    #3;
    chk("lr_rst_rvalid", ldr_rvalid, 0);
    chk("lr_rst_rdata", ldr_rdata, 0);
    step();
    step();
    reset = 1;

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      step();
      if (!reset) reset = 1;
      else if ($urandom_range(0, 199) == 0) reset = 0;
      cpu_req = ($urandom_range(0, 9) < 8);
      cpu_we_a = ($urandom_range(0, 3) == 0);
      cpu_we_b = ($urandom_range(0, 3) == 0);
      cpu_addr = 16'($urandom);
      cpu_wdata_a = 8'($urandom);
      cpu_wdata_b = {$urandom, $urandom, $urandom, $urandom};
      ldr_req = ($urandom_range(0, 9) < 7);
      ldr_we = ($urandom_range(0, 2) == 0);
      ldr_vec = 1'($urandom);
      ldr_addr = 16'($urandom);
      ldr_wdata = {$urandom, $urandom, $urandom, $urandom};
      ram_q_a = 8'($urandom);
      ram_q_b = {$urandom, $urandom, $urandom, $urandom};
    end
    step();
    #6;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares the dual-port data RAM (port a: 8-bit scalar, port b: 128-bit vector) between two requesters: the CPU memory stage and an external bulk loader (image/vector preload, readback).
- Sits between the ExecuteMemory pipeline register and the RAM.
- The CPU has priority. An optional starvation guard forces a one-cycle loader grant and stalls the CPU.
- Read data returns one cycle after grant and is routed back to the requester that issued the read.

## Interface
Parameters:
- STARVE_LIMIT, 8, number of denied loader cycles before a forced grant (range 1..15).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU memory-stage access request this cycle.
- cpu_we_a  in  1  CPU scalar write (port a).
- cpu_we_b  in  1  CPU vector write (port b).
- cpu_addr  in  16  CPU address; port b uses [11:0].
- cpu_wdata_a  in  8  CPU scalar write data.
- cpu_wdata_b  in  128  CPU vector write data.
- cpu_stall  out  1  CPU request denied this cycle; pipeline must hold.
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata_a  out  8  CPU scalar read data.
- cpu_rdata_b  out  128  CPU vector read data.
- ldr_req  in  1  loader request.
- ldr_we  in  1  loader write.
- ldr_vec  in  1  1 = port b (128-bit), 0 = port a (wdata[7:0]).
- ldr_addr  in  16  loader address.
- ldr_wdata  in  128  loader write data.
- ldr_gnt  out  1  loader granted this cycle.
- ldr_rvalid  out  1  loader read data valid.
- ldr_rdata  out  128  loader read data; scalar reads zero-extended.
- ram_address_a  out  16  RAM port a address.
- ram_address_b  out  12  RAM port b address.
- ram_data_a  out  8  RAM port a write data.
- ram_data_b  out  128  RAM port b write data.
- ram_wren_a  out  1  RAM port a write enable.
- ram_wren_b  out  1  RAM port b write enable.
- ram_q_a  in  8  RAM port a read data (1-cycle registered).
- ram_q_b  in  128  RAM port b read data (1-cycle registered).

## Operation
- Grant decision is combinational from the current requests and registered state.
  - FORCE condition: guard compiled in, ldr_req=1, starve_cnt==STARVE_LIMIT. Loader wins.
  - Otherwise, if cpu_req=1: CPU wins.
  - Otherwise, if ldr_req=1: loader wins.
  - Otherwise: no grant; RAM wren=0 and addresses=0.
- The winner's address, data and write enables drive the RAM.
  - Loader with ldr_vec=0 drives port a only.
  - Loader with ldr_vec=1 drives port b only.
  - The CPU drives both addresses.
- FSM register records the last-cycle grant: IDLE, CPU, LDR, FORCE.
  - Next state = grant type of the current cycle.
  - A read flag is registered alongside the state.
- Read return: the cycle after a granted read (all write enables 0), pulse the owner's rvalid for 1 cycle with ram_q data.
  - FORCE routes to the loader.
  - Writes produce no rvalid.
- Starvation counter (4-bit):
  - Increments each cycle ldr_req=1 and the CPU wins.
  - Clears when the loader is granted or ldr_req=0.
  - Saturates at STARVE_LIMIT.
- cpu_stall=1 only when cpu_req=1 in a FORCE cycle.
- Boundary conditions:
  - Loader drops its request while waiting: counter clears, no grant.
  - Both requesters issue reads back-to-back: returns stay ordered by the registered owner.
  - A FORCE grant lasts exactly 1 cycle, then the CPU is regranted.
- Reset low (any time):
  - Outputs 0, state IDLE, counter 0.
  - Any pending rvalid is discarded.

## Timing
- Grant/stall: 0-cycle (same cycle as request).
- Read latency: 1 cycle from grant to rvalid.
- Write: takes effect at the grant cycle's clock edge.
- Loader worst-case wait under continuous cpu_req: STARVE_LIMIT denied cycles, granted on cycle STARVE_LIMIT+1.
- cpu_rdata/ldr_rdata hold their last value when rvalid=0; reset value 0.

## Configuration
- ARB_STARVE_GUARD_EN defined: starvation counter and FORCE state are present; cpu_stall is functional.
- Not defined:
  - Strict CPU priority; the counter and FORCE state are removed.
  - cpu_stall is tied 0.
  - The loader is served only when cpu_req=0.

## Structure
- Package mem_arb_pkg:
  - arb_state_e enum (IDLE, CPU, LDR, FORCE).
  - Width constants: ADDR_W=16, VADDR_W=12, SDATA_W=8, VDATA_W=128.
- Sub-module arb_starve_counter: counter plus saturation compare, instantiated only under ARB_STARVE_GUARD_EN.

## Test plan
- Reset: hold reset=0 with both requesters active -> all outputs 0; after release, first grant goes to the CPU.
- CPU scalar read at 0x0010, ram_q_a=0x5A -> ram_address_a=0x0010 in the grant cycle; next cycle cpu_rvalid=1, cpu_rdata_a=0x5A.
- Loader vector write alone, ldr_addr=0x0200, data 128'hA5... -> ldr_gnt=1 the same cycle, ram_wren_b=1, ram_address_b=0x200, no rvalid.
- Continuous cpu_req and ldr_req, STARVE_LIMIT=8, guard on:
  - CPU granted cycles 1-8.
  - Cycle 9: ldr_gnt=1, cpu_stall=1.
  - Cycle 10: CPU granted again, counter 0.
- Same stimulus with the guard off -> ldr_gnt never asserts while cpu_req=1; cpu_stall stays 0.
- Loader read granted, then reset=0 in the next cycle -> ldr_rvalid stays 0; state IDLE.
